// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, FSM state encoding and the parity helper,
// common to the transmitter and the future parametrised receiver.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

  localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
  localparam logic [2:0] ST_START_ENC  = 3'd1;
  localparam logic [2:0] ST_DATA_ENC   = 3'd2;
  localparam logic [2:0] ST_PARITY_ENC = 3'd3;
  localparam logic [2:0] ST_STOP_ENC   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_START  = ST_START_ENC,
    ST_DATA   = ST_DATA_ENC,
    ST_PARITY = ST_PARITY_ENC,
    ST_STOP   = ST_STOP_ENC
  } uart_state_e;

  // Word is zero-extended, so the extra high bits do not disturb the XOR.
  function automatic logic parity_bit(input logic [15:0] word, input logic [1:0] mode);
    logic p;
    p = ^word;
    if (mode == PAR_ODD) begin
      return ~p;
    end else begin
      return p;
    end
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered read data (updated on pop) and occupancy count.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic [WIDTH-1:0] pop_data_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == (AW+1)'(0));
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign pop_data  = pop_data_r;
  assign count     = count_r;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers, occupancy and read register; pointers wrap naturally at power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {(AW+1){1'b0}};
      pop_data_r <= {WIDTH{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_ok_s) begin
        pop_data_r <= mem_r[rd_ptr_r];
        rd_ptr_r   <= rd_ptr_r + 1'b1;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter fed by a small FIFO; frames are sent back-to-back
// while data is buffered, and tx_done pulses during the last stop-bit cycle on the line.
module uart_tx_fifo_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 435,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tx_valid,
  input  logic [DATA_BITS-1:0]        tx_data,
  output logic                        tx_ready,
  output logic                        tx_serial_out,
  output logic                        tx_active,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int             CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [1:0]     PAR_MODE  = 2'(PARITY);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_fifo_param: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_fifo_param: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_tx_fifo_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_fifo_param: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo_param: FIFO_DEPTH must be a power of two >= 2");
  end

  uart_state_e          state_r, state_s;
  logic [CW-1:0]        cnt_r, cnt_s;
  logic [3:0]           bit_r, bit_s;
  logic                 serial_r, active_r, done_r;
  logic                 line_s, active_s, done_s;
  logic                 push_s, pop_s, full_s, empty_s, par_s;
  logic [DATA_BITS-1:0] word_s;
  logic [15:0]          word_ext_s;

  assign tx_ready      = ~full_s;
  assign push_s        = tx_valid & ~full_s;
  assign word_ext_s    = 16'(word_s);
  assign par_s         = parity_bit(word_ext_s, PAR_MODE);
  assign tx_serial_out = serial_r;
  assign tx_active     = active_r;
  assign tx_done       = done_r;

  // The FIFO read register doubles as the latched word for the frame in flight.
  uart_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (tx_data),
    .pop       (pop_s),
    .pop_data  (word_s),
    .full      (full_s),
    .empty     (empty_s),
    .count     (fifo_count)
  );

  // Next-state logic; line/active/done describe the current state and are registered.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    bit_s    = bit_r;
    pop_s    = 1'b0;
    line_s   = 1'b1;
    active_s = 1'b0;
    done_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          state_s = ST_START;
          cnt_s   = {CW{1'b0}};
          bit_s   = 4'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        line_s   = 1'b0;
        active_s = 1'b1;
        if (cnt_r == CNT_LAST) begin
          cnt_s   = {CW{1'b0}};
          bit_s   = 4'd0;
          state_s = ST_DATA;
        end else begin
          cnt_s = cnt_r + 1'b1;
        end
      end
      ST_DATA: begin
        line_s   = word_ext_s[bit_r];
        active_s = 1'b1;
        if (cnt_r == CNT_LAST) begin
          cnt_s = {CW{1'b0}};
          if (bit_r == DATA_LAST) begin
            bit_s = 4'd0;
            if (PAR_MODE != PAR_NONE) begin
              state_s = ST_PARITY;
            end else begin
              state_s = ST_STOP;
            end
          end else begin
            bit_s = bit_r + 4'd1;
          end
        end else begin
          cnt_s = cnt_r + 1'b1;
        end
      end
      ST_PARITY: begin
        line_s   = par_s;
        active_s = 1'b1;
        if (cnt_r == CNT_LAST) begin
          cnt_s   = {CW{1'b0}};
          bit_s   = 4'd0;
          state_s = ST_STOP;
        end else begin
          cnt_s = cnt_r + 1'b1;
        end
      end
      ST_STOP: begin
        line_s   = 1'b1;
        active_s = 1'b1;
        if (cnt_r == CNT_LAST) begin
          cnt_s = {CW{1'b0}};
          if (bit_r == STOP_LAST) begin
            done_s = 1'b1;
            bit_s  = 4'd0;
            // Chain straight into the next start bit when more data is waiting.
            if (!empty_s) begin
              pop_s   = 1'b1;
              state_s = ST_START;
            end else begin
              state_s = ST_IDLE;
            end
          end else begin
            bit_s = bit_r + 4'd1;
          end
        end else begin
          cnt_s = cnt_r + 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = {CW{1'b0}};
        bit_s   = 4'd0;
      end
    endcase
  end

  // State, counters and registered line outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CW{1'b0}};
      bit_r    <= 4'd0;
      serial_r <= 1'b1;
      active_r <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      bit_r    <= bit_s;
      serial_r <= line_s;
      active_r <= active_s;
      done_r   <= done_s;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Bench for uart_tx_fifo_param: four configurations at 4 clocks/bit, table-driven frames
// checked by a scoreboard-fed line monitor, plus back-to-back and mid-frame reset sequences.
module tb_uart_tx_fifo_param;

  localparam int CPB = 4;
  localparam int NV  = 10;

  typedef struct {
    int         dut;
    logic [8:0] word;
    logic [11:0] frame;
    int         nbits;
  } vec_t;

  typedef struct {
    int          dut;
    logic [11:0] frame;
    int          nbits;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       valid [4];
  logic [8:0] data  [4];
  logic       rdy   [4];
  logic       ser   [4];
  logic       act   [4];
  logic       dn    [4];
  logic       busy  [4];
  int         stray [4];
  logic [2:0] cnt_a;
  logic [4:0] cnt_e, cnt_o, cnt_s;

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb_q[$];
  vec_t tbl[NV];

  // 8N1 with a 4-entry FIFO
  uart_tx_fifo_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .tx_valid(valid[0]), .tx_data(data[0][7:0]), .tx_ready(rdy[0]),
    .tx_serial_out(ser[0]), .tx_active(act[0]), .tx_done(dn[0]), .fifo_count(cnt_a));
  // 7E1
  uart_tx_fifo_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) dut_e (
    .clk(clk), .rst(rst), .tx_valid(valid[1]), .tx_data(data[1][6:0]), .tx_ready(rdy[1]),
    .tx_serial_out(ser[1]), .tx_active(act[1]), .tx_done(dn[1]), .fifo_count(cnt_e));
  // 7O1
  uart_tx_fifo_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) dut_o (
    .clk(clk), .rst(rst), .tx_valid(valid[2]), .tx_data(data[2][6:0]), .tx_ready(rdy[2]),
    .tx_serial_out(ser[2]), .tx_active(act[2]), .tx_done(dn[2]), .fifo_count(cnt_o));
  // 8N2
  uart_tx_fifo_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16)) dut_s (
    .clk(clk), .rst(rst), .tx_valid(valid[3]), .tx_data(data[3][7:0]), .tx_ready(rdy[3]),
    .tx_serial_out(ser[3]), .tx_active(act[3]), .tx_done(dn[3]), .fifo_count(cnt_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int get_cnt(input int idx);
    case (idx)
      0:       return int'(cnt_a);
      1:       return int'(cnt_e);
      2:       return int'(cnt_o);
      3:       return int'(cnt_s);
      default: return -1;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Watches one serial line; each frame is compared against the oldest scoreboard entry.
  task automatic monitor(input int idx);
    exp_t        e;
    int          k, len;
    logic [63:0] got_w, exp_w, got_d, exp_d;
    logic        act_ok, in_frame, lost;
    in_frame = 1'b0; lost = 1'b0; k = 0; len = 0; act_ok = 1'b1;
    got_w = 64'd0; exp_w = 64'd0; got_d = 64'd0; exp_d = 64'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame  = 1'b0;
        lost      = 1'b0;
        busy[idx] = 1'b0;
      end else begin
        if (lost) begin
          if (ser[idx]) lost = 1'b0;
        end else if (!in_frame) begin
          if (ser[idx] == 1'b0) begin
            if (sb_q.size() > 0 && sb_q[0].dut == idx) begin
              e = sb_q.pop_front();
              in_frame = 1'b1; busy[idx] = 1'b1;
              k = 0; len = e.nbits * CPB; act_ok = 1'b1;
              got_w = 64'd0; got_d = 64'd0; exp_w = 64'd0;
              for (int b = 0; b < len; b++) exp_w[b] = e.frame[b / CPB];
              exp_d = 64'd1 << (len - 1);
            end else begin
              n_cmp++; n_fail++; lost = 1'b1;
              $display("FAIL unexpected_start dut%0d: got start bit, expected idle line", idx);
            end
          end else if (act[idx] || dn[idx]) begin
            stray[idx]++;
          end
        end
        if (in_frame) begin
          got_w[k] = ser[idx];
          got_d[k] = dn[idx];
          if (!act[idx]) act_ok = 1'b0;
          k++;
          if (k == len) begin
            check($sformatf("frame_line_dut%0d", idx), got_w, exp_w);
            check($sformatf("frame_done_dut%0d", idx), got_d, exp_d);
            check($sformatf("frame_active_dut%0d", idx), 64'(act_ok), 64'd1);
            in_frame = 1'b0; busy[idx] = 1'b0;
          end
        end
      end
    end
  endtask

  // Offers one word, waits for acceptance, and records the frame it should produce.
  task automatic push_word(input int idx, input logic [8:0] w, input logic [11:0] fr, input int nb);
    int   guard;
    exp_t e;
    @(negedge clk);
    valid[idx] = 1'b1; data[idx] = w; guard = 0;
    while (!rdy[idx] && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) begin
      n_cmp++; n_fail++;
      $display("FAIL push_timeout dut%0d: tx_ready stayed 0, expected 1", idx);
      valid[idx] = 1'b0;
    end else begin
      @(posedge clk);
      e.dut = idx; e.frame = fr; e.nbits = nb;
      sb_q.push_back(e);
      #1 valid[idx] = 1'b0;
    end
  endtask

  task automatic wait_idle(input int idx);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while ((sb_q.size() != 0 || busy[idx] || act[idx]) && guard < 3000);
    if (guard >= 3000) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout dut%0d: queue %0d, expected 0", idx, sb_q.size());
    end
  endtask

  // Single push into an idle block: pop one edge later, start bit two edges later.
  task automatic send_vec(input vec_t v);
    push_word(v.dut, v.word, v.frame, v.nbits);
    @(negedge clk);
    check($sformatf("lat_count1_dut%0d", v.dut), 64'(get_cnt(v.dut)), 64'd1);
    check($sformatf("lat_idle1_dut%0d", v.dut), 64'(ser[v.dut]), 64'd1);
    @(negedge clk);
    check($sformatf("lat_count0_dut%0d", v.dut), 64'(get_cnt(v.dut)), 64'd0);
    check($sformatf("lat_idle2_dut%0d", v.dut), 64'(ser[v.dut]), 64'd1);
    @(negedge clk);
    check($sformatf("lat_start_dut%0d", v.dut), 64'(ser[v.dut]), 64'd0);
    wait_idle(v.dut);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int gaps, pulses, rbad, g;
    logic saw_full;

    // Frame bits listed stop..start (bit 0 = start bit); parity bits worked out by hand.
    tbl[0] = '{0, 9'h0A5, {2'b00, 1'b1, 8'hA5, 1'b0}, 10};
    tbl[1] = '{0, 9'h080, {2'b00, 1'b1, 8'h80, 1'b0}, 10};
    tbl[2] = '{1, 9'h055, {2'b00, 1'b1, 1'b0, 7'h55, 1'b0}, 10};
    tbl[3] = '{1, 9'h003, {2'b00, 1'b1, 1'b0, 7'h03, 1'b0}, 10};
    tbl[4] = '{1, 9'h001, {2'b00, 1'b1, 1'b1, 7'h01, 1'b0}, 10};
    tbl[5] = '{2, 9'h055, {2'b00, 1'b1, 1'b1, 7'h55, 1'b0}, 10};
    tbl[6] = '{2, 9'h07F, {2'b00, 1'b1, 1'b0, 7'h7F, 1'b0}, 10};
    tbl[7] = '{2, 9'h000, {2'b00, 1'b1, 1'b1, 7'h00, 1'b0}, 10};
    tbl[8] = '{3, 9'h0FF, {1'b0, 2'b11, 8'hFF, 1'b0}, 11};
    tbl[9] = '{3, 9'h000, {1'b0, 2'b11, 8'h00, 1'b0}, 11};

    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      valid[i] = 1'b1; data[i] = 9'h1FF; busy[i] = 1'b0; stray[i] = 0;
    end
    fork
      monitor(0);
      monitor(1);
      monitor(2);
      monitor(3);
    join_none

    // Reset held three cycles with tx_valid high.
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i += 3) begin
      check($sformatf("rst_serial_dut%0d", i), 64'(ser[i]), 64'd1);
      check($sformatf("rst_ready_dut%0d", i), 64'(rdy[i]), 64'd1);
      check($sformatf("rst_count_dut%0d", i), 64'(get_cnt(i)), 64'd0);
      check($sformatf("rst_active_dut%0d", i), 64'(act[i]), 64'd0);
      check($sformatf("rst_done_dut%0d", i), 64'(dn[i]), 64'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) valid[i] = 1'b0;
    @(negedge clk);
    check("post_rst_count", 64'(get_cnt(0)), 64'd0);

    for (int i = 0; i < NV; i++) send_vec(tbl[i]);

    // Six words through a 4-deep FIFO with tx_valid held high.
    gaps = 0; pulses = 0; rbad = 0; saw_full = 1'b0;
    fork
      begin
        for (int w = 1; w <= 6; w++)
          push_word(0, 9'(w), {2'b00, 1'b1, 8'(w), 1'b0}, 10);
      end
      begin
        g = 0;
        do begin
          @(negedge clk);
          g++;
        end while (ser[0] !== 1'b0 && g < 100);
        for (int c = 0; c < 6 * 10 * CPB; c++) begin
          if (c != 0) @(negedge clk);
          if (!act[0]) gaps++;
          if (dn[0]) pulses++;
        end
      end
      begin
        repeat (260) begin
          @(negedge clk);
          if (rdy[0] !== (cnt_a != 3'd4)) rbad++;
          if (cnt_a == 3'd4) saw_full = 1'b1;
        end
      end
    join
    check("b2b_active_gaps", 64'(gaps), 64'd0);
    check("b2b_done_pulses", 64'(pulses), 64'd6);
    check("b2b_ready_vs_full", 64'(rbad), 64'd0);
    check("b2b_reached_full", 64'(saw_full), 64'd1);
    wait_idle(0);

    // Reset during data bit 3 with two words still queued.
    push_word(0, 9'h011, {2'b00, 1'b1, 8'h11, 1'b0}, 10);
    push_word(0, 9'h022, {2'b00, 1'b1, 8'h22, 1'b0}, 10);
    push_word(0, 9'h033, {2'b00, 1'b1, 8'h33, 1'b0}, 10);
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (ser[0] !== 1'b0 && g < 100);
    repeat (4 * CPB + 1) @(negedge clk);
    check("midrst_queued", 64'(cnt_a), 64'd2);
    check("midrst_line_in_bit3", 64'(ser[0]), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_serial", 64'(ser[0]), 64'd1);
    check("midrst_count", 64'(cnt_a), 64'd0);
    check("midrst_done", 64'(dn[0]), 64'd0);
    check("midrst_active", 64'(act[0]), 64'd0);
    check("midrst_ready", 64'(rdy[0]), 64'd1);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send_vec('{0, 9'h03C, {2'b00, 1'b1, 8'h3C, 1'b0}, 10});
    repeat (10) @(negedge clk);

    for (int i = 0; i < 4; i++)
      check($sformatf("idle_stray_dut%0d", i), 64'(stray[i]), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
